// File: rtl/traffic_pkg.sv
// Shared types and lane/pedestrian mapping for the intersection phase scheduler.
// PREEMPT_EN adds the HOLD state used by emergency-vehicle preemption.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
`ifdef PREEMPT_EN
    ,
    ST_HOLD    = 2'd3
`endif
  } state_e;

  localparam logic [1:0] SS_STRAIGHT = 2'd0;
  localparam logic [1:0] SS_TURN     = 2'd1;
  localparam logic [1:0] CS_STRAIGHT = 2'd2;
  localparam logic [1:0] CS_TURN     = 2'd3;

  // Phase served by pedestrian crossing j.
  function automatic logic [1:0] ped_phase(input logic j);
    return j ? CS_STRAIGHT : SS_STRAIGHT;
  endfunction

  // Crossing bits served by phase p (inverse of ped_phase).
  function automatic logic [1:0] ped_mask(input logic [1:0] p);
    return {p == CS_STRAIGHT, p == SS_STRAIGHT};
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

endpackage

// File: rtl/rr_phase_picker.sv
// Combinational round-robin picker: scans phase+1 .. phase+4 (mod 4) and
// returns the first requesting lane, or lane 0 when nothing is requested.
module rr_phase_picker
  import traffic_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] phase_i,
  output logic [1:0] pick_o
);

  logic       found;
  logic [1:0] idx;

  // First set request at or after phase+1, wrapping back to the current phase.
  always_comb begin
    pick_o = SS_STRAIGHT;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = phase_i + 2'(k);
      if (!found && req_i[idx]) begin
        pick_o = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// Demand-driven traffic phase scheduler: latches car/pedestrian requests,
// picks phases round-robin and sequences GREEN -> YELLOW -> ALL_RED with
// sensor-extended green bounded by minimum and maximum times.
// Optional macro PREEMPT_EN adds the preempt input and a HOLD state.
module phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN    = 10,
  parameter int GREEN_MAX    = 60,
  parameter int YELLOW_TIME  = 4,
  parameter int ALL_RED_TIME = 2,
  parameter int WALK_TIME    = 8,
  parameter int TIMER_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1s,
  input  logic [3:0]         car_sensor,
  input  logic [1:0]         ped_button,
`ifdef PREEMPT_EN
  input  logic               preempt,
`endif
  output logic [3:0]         green,
  output logic [3:0]         yellow,
  output logic [3:0]         red,
  output logic [1:0]         walk,
  output logic [1:0]         phase,
  output logic [TIMER_W-1:0] interval_timer
);

  localparam int GMIN_PED = (WALK_TIME > GREEN_MIN) ? WALK_TIME : GREEN_MIN;
  localparam logic [TIMER_W-1:0] T_GMIN     = TIMER_W'(GREEN_MIN);
  localparam logic [TIMER_W-1:0] T_GMIN_PED = TIMER_W'(GMIN_PED);
  localparam logic [TIMER_W-1:0] T_GMAX     = TIMER_W'(GREEN_MAX);
  localparam logic [TIMER_W-1:0] T_YELLOW   = TIMER_W'(YELLOW_TIME);
  localparam logic [TIMER_W-1:0] T_ALLRED   = TIMER_W'(ALL_RED_TIME);
  localparam logic [TIMER_W-1:0] T_WALK     = TIMER_W'(WALK_TIME);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         phase_q, phase_d;
  logic [3:0]         req_q, req_d;
  logic [1:0]         ped_req_q, ped_req_d;
  logic               ped_srv_q, ped_srv_d;
  logic [3:0]         green_q, green_d, yellow_q, yellow_d, red_q, red_d;
  logic [1:0]         walk_q, walk_d;

  logic [1:0]         pick;
  logic               enter_green;
  logic [TIMER_W-1:0] t1;
  logic [TIMER_W-1:0] eff_min;
  logic               other_req;
  logic [3:0]         car_set, ped_lanes, req_clr;
  logic [1:0]         ped_set, ped_now, ped_clr;

  rr_phase_picker u_picker (
    .req_i   (req_q),
    .phase_i (phase_q),
    .pick_o  (pick)
  );

  // Next state, request latches and registered lamp values.
  // Lamps are computed from the next-state values so they change on the
  // same edge as the state itself.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    ped_srv_d   = ped_srv_q;
    enter_green = 1'b0;

    t1        = (&timer_q) ? timer_q : timer_q + TIMER_W'(1);
    eff_min   = ped_srv_q ? T_GMIN_PED : T_GMIN;
    other_req = |(req_q & ~lane_mask(phase_q));

    unique case (state_q)
      ST_ALL_RED: begin
        if (tick_1s) begin
`ifdef PREEMPT_EN
          if (preempt) begin
            state_d = ST_HOLD;
          end else
`endif
          if (t1 >= T_ALLRED) begin
            state_d     = ST_GREEN;
            phase_d     = pick;
            enter_green = 1'b1;
            ped_srv_d   = |(ped_mask(pick) & ped_req_q);
          end
        end
      end
      ST_GREEN: begin
        if (tick_1s) begin
`ifdef PREEMPT_EN
          if (preempt) begin
            state_d = ST_YELLOW;
          end else
`endif
          if (t1 >= eff_min && other_req &&
              (!car_sensor[phase_q] || t1 >= T_GMAX)) begin
            state_d = ST_YELLOW;
          end
        end
      end
      ST_YELLOW: begin
        if (tick_1s && t1 >= T_YELLOW) state_d = ST_ALL_RED;
      end
`ifdef PREEMPT_EN
      ST_HOLD: begin
        if (tick_1s && !preempt) state_d = ST_ALL_RED;
      end
`endif
      default: state_d = ST_ALL_RED;
    endcase

    if (state_d != state_q) timer_d = '0;
    else if (tick_1s)       timer_d = t1;
    else                    timer_d = timer_q;

    // Car demand on the lane currently green is not latched; pedestrian
    // presses are ignored while their own walk lamp is lit.
    car_set   = car_sensor & ~((state_q == ST_GREEN) ? lane_mask(phase_q) : 4'b0000);
    ped_set   = ped_button & ~walk_q;
    ped_now   = ped_req_q | ped_set;
    ped_lanes = '0;
    ped_lanes[ped_phase(1'b0)] = ped_now[0];
    ped_lanes[ped_phase(1'b1)] = ped_now[1];
    req_clr   = enter_green ? lane_mask(pick) : '0;
    ped_clr   = enter_green ? ped_mask(pick) : '0;
    req_d     = (req_q | car_set | ped_lanes) & ~req_clr;
    ped_req_d = ped_now & ~ped_clr;

    green_d  = (state_d == ST_GREEN)  ? lane_mask(phase_d) : '0;
    yellow_d = (state_d == ST_YELLOW) ? lane_mask(phase_d) : '0;
    red_d    = ~(green_d | yellow_d);
    walk_d   = (state_d == ST_GREEN && ped_srv_d && timer_d < T_WALK) ?
               ped_mask(phase_d) : '0;
  end

  // State, timer, request and lamp registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ALL_RED;
      timer_q   <= '0;
      phase_q   <= CS_TURN;
      req_q     <= '0;
      ped_req_q <= '0;
      ped_srv_q <= 1'b0;
      green_q   <= '0;
      yellow_q  <= '0;
      red_q     <= '1;
      walk_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      phase_q   <= phase_d;
      req_q     <= req_d;
      ped_req_q <= ped_req_d;
      ped_srv_q <= ped_srv_d;
      green_q   <= green_d;
      yellow_q  <= yellow_d;
      red_q     <= red_d;
      walk_q    <= walk_d;
    end
  end

  assign green          = green_q;
  assign yellow         = yellow_q;
  assign red            = red_q;
  assign walk           = walk_q;
  assign phase          = phase_q;
  assign interval_timer = timer_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Self-checking bench for phase_scheduler: a vector table of
// {car inputs, tick count, expected lamps/phase/timer} plus hand sequences
// for round-robin order, pedestrian walk and asynchronous reset.
module tb_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1s;
  logic [3:0] car_sensor;
  logic [1:0] ped_button;
`ifdef PREEMPT_EN
  logic       preempt = 1'b0;
`endif
  logic [3:0] green, yellow, red;
  logic [1:0] walk, phase;
  logic [7:0] interval_timer;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [3:0] g;
    logic [3:0] y;
    logic [1:0] w;
    logic [1:0] p;
    logic [7:0] t;
  } exp_t;

  typedef struct {
    string      name;
    logic [3:0] car;
    int         n;
    logic [3:0] g;
    logic [3:0] y;
    logic [1:0] w;
    logic [1:0] p;
    logic [7:0] t;
  } vec_t;

  exp_t sb[$];
  vec_t tab[20];

  phase_scheduler #(
    .GREEN_MIN    (10),
    .GREEN_MAX    (60),
    .YELLOW_TIME  (4),
    .ALL_RED_TIME (2),
    .WALK_TIME    (8),
    .TIMER_W      (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tick_1s        (tick_1s),
    .car_sensor     (car_sensor),
    .ped_button     (ped_button),
`ifdef PREEMPT_EN
    .preempt        (preempt),
`endif
    .green          (green),
    .yellow         (yellow),
    .red            (red),
    .walk           (walk),
    .phase          (phase),
    .interval_timer (interval_timer)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic [3:0] car, input int n,
                              input logic [3:0] g, input logic [3:0] y,
                              input logic [1:0] w, input logic [1:0] p,
                              input logic [7:0] t);
    vec_t v;
    v.name = name; v.car = car; v.n = n;
    v.g = g; v.y = y; v.w = w; v.p = p; v.t = t;
    return v;
  endfunction

  task automatic expect_now(input string name, input logic [3:0] g, input logic [3:0] y,
                            input logic [1:0] w, input logic [1:0] p, input logic [7:0] t);
    exp_t e;
    e.name = name; e.g = g; e.y = y; e.w = w; e.p = p; e.t = t;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [3:0] r_exp;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e = sb.pop_front();
      r_exp = ~(e.g | e.y);
      if (green !== e.g || yellow !== e.y || red !== r_exp || walk !== e.w ||
          phase !== e.p || interval_timer !== e.t) begin
        n_fail++;
        $display("FAIL %s: got g=%b y=%b r=%b w=%b p=%0d t=%0d, want g=%b y=%b r=%b w=%b p=%0d t=%0d",
                 e.name, green, yellow, red, walk, phase, interval_timer,
                 e.g, e.y, r_exp, e.w, e.p, e.t);
      end
    end
  endtask

  // Each tick: one idle cycle (lets requests latch), one strobe cycle, then
  // sampling happens on a falling edge.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick_1s = 1'b1;
      @(negedge clk); tick_1s = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_row(input vec_t v);
    car_sensor = v.car;
    expect_now(v.name, v.g, v.y, v.w, v.p, v.t);
    tick_n(v.n);
    check_out();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick_1s = 1'b0; car_sensor = '0; ped_button = '0;
    repeat (3) @(negedge clk);
    expect_now("reset_state", 4'b0000, 4'b0000, 2'b00, 2'd3, 8'd0);
    check_out();
    rst = 1'b0;
  endtask

  initial begin
    tab[0]  = mk("idle_to_rest0",   4'b0000,   2, 4'b0001, 4'b0000, 2'b00, 2'd0, 8'd0);
    tab[1]  = mk("rest0_100",       4'b0000, 100, 4'b0001, 4'b0000, 2'b00, 2'd0, 8'd100);
    tab[2]  = mk("rest_exit_yel",   4'b0100,   1, 4'b0000, 4'b0001, 2'b00, 2'd0, 8'd0);
    tab[3]  = mk("yellow_t3",       4'b0100,   3, 4'b0000, 4'b0001, 2'b00, 2'd0, 8'd3);
    tab[4]  = mk("allred_t0",       4'b0100,   1, 4'b0000, 4'b0000, 2'b00, 2'd0, 8'd0);
    tab[5]  = mk("allred_t1",       4'b0000,   1, 4'b0000, 4'b0000, 2'b00, 2'd0, 8'd1);
    tab[6]  = mk("green2",          4'b0000,   1, 4'b0100, 4'b0000, 2'b00, 2'd2, 8'd0);
    tab[7]  = mk("min_green_t9",    4'b0001,   9, 4'b0100, 4'b0000, 2'b00, 2'd2, 8'd9);
    tab[8]  = mk("min_green_exit",  4'b0001,   1, 4'b0000, 4'b0100, 2'b00, 2'd2, 8'd0);
    tab[9]  = mk("allred_after2",   4'b0000,   4, 4'b0000, 4'b0000, 2'b00, 2'd2, 8'd0);
    tab[10] = mk("green0",          4'b0000,   2, 4'b0001, 4'b0000, 2'b00, 2'd0, 8'd0);
    tab[11] = mk("max_green_t59",   4'b0011,  59, 4'b0001, 4'b0000, 2'b00, 2'd0, 8'd59);
    tab[12] = mk("max_green_exit",  4'b0011,   1, 4'b0000, 4'b0001, 2'b00, 2'd0, 8'd0);
    tab[13] = mk("allred_after0",   4'b0000,   4, 4'b0000, 4'b0000, 2'b00, 2'd0, 8'd0);
    tab[14] = mk("green1",          4'b0000,   2, 4'b0010, 4'b0000, 2'b00, 2'd1, 8'd0);
    tab[15] = mk("green1_t9",       4'b0000,   9, 4'b0010, 4'b0000, 2'b00, 2'd1, 8'd9);
    tab[16] = mk("green1_exit",     4'b0000,   1, 4'b0000, 4'b0010, 2'b00, 2'd1, 8'd0);
    tab[17] = mk("allred_after1",   4'b0000,   4, 4'b0000, 4'b0000, 2'b00, 2'd1, 8'd0);
    tab[18] = mk("green0_again",    4'b0000,   2, 4'b0001, 4'b0000, 2'b00, 2'd0, 8'd0);
    tab[19] = mk("rest0_30",        4'b0000,  30, 4'b0001, 4'b0000, 2'b00, 2'd0, 8'd30);

    do_reset();
    for (int i = 0; i < 20; i++) run_row(tab[i]);

    // Asynchronous reset mid-interval: outputs must drop without a clock edge.
    @(negedge clk); #2 rst = 1'b1;
    #1;
    expect_now("async_reset", 4'b0000, 4'b0000, 2'b00, 2'd3, 8'd0);
    check_out();
    @(negedge clk); rst = 1'b0;

    // Round robin from phase 2 with lanes 1 and 3 requesting: 3 then 1.
    do_reset();
    run_row(mk("rr_green2",     4'b0100,  2, 4'b0100, 4'b0000, 2'b00, 2'd2, 8'd0));
    run_row(mk("rr_g2_t9",      4'b1010,  9, 4'b0100, 4'b0000, 2'b00, 2'd2, 8'd9));
    run_row(mk("rr_yel2",       4'b1010,  1, 4'b0000, 4'b0100, 2'b00, 2'd2, 8'd0));
    run_row(mk("rr_allred2",    4'b1010,  4, 4'b0000, 4'b0000, 2'b00, 2'd2, 8'd0));
    run_row(mk("rr_green3",     4'b1010,  2, 4'b1000, 4'b0000, 2'b00, 2'd3, 8'd0));
    run_row(mk("rr_yel3",       4'b0000, 10, 4'b0000, 4'b1000, 2'b00, 2'd3, 8'd0));
    run_row(mk("rr_allred3",    4'b0000,  4, 4'b0000, 4'b0000, 2'b00, 2'd3, 8'd0));
    run_row(mk("rr_green1",     4'b0000,  2, 4'b0010, 4'b0000, 2'b00, 2'd1, 8'd0));

    // Pedestrian crossing 1 with a short car demand on lane 2.
    do_reset();
    car_sensor = 4'b0100; ped_button = 2'b10;
    @(negedge clk);
    ped_button = 2'b00; car_sensor = 4'b0000;
    run_row(mk("ped_walk_on",   4'b0000,  2, 4'b0100, 4'b0000, 2'b10, 2'd2, 8'd0));
    run_row(mk("ped_walk_t7",   4'b0001,  7, 4'b0100, 4'b0000, 2'b10, 2'd2, 8'd7));
    ped_button = 2'b10;
    @(negedge clk);
    ped_button = 2'b00;
    run_row(mk("ped_walk_off",  4'b0001,  1, 4'b0100, 4'b0000, 2'b00, 2'd2, 8'd8));
    run_row(mk("ped_min_t9",    4'b0001,  1, 4'b0100, 4'b0000, 2'b00, 2'd2, 8'd9));
    run_row(mk("ped_exit_yel",  4'b0001,  1, 4'b0000, 4'b0100, 2'b00, 2'd2, 8'd0));
    run_row(mk("ped_allred",    4'b0000,  4, 4'b0000, 4'b0000, 2'b00, 2'd2, 8'd0));
    run_row(mk("ped_green0",    4'b0000,  2, 4'b0001, 4'b0000, 2'b00, 2'd0, 8'd0));
    run_row(mk("ped_no_rereq",  4'b0000, 20, 4'b0001, 4'b0000, 2'b00, 2'd0, 8'd20));

`ifdef PREEMPT_EN
    do_reset();
    run_row(mk("pre_green0",    4'b0000,  2, 4'b0001, 4'b0000, 2'b00, 2'd0, 8'd0));
    run_row(mk("pre_g0_t3",     4'b0000,  3, 4'b0001, 4'b0000, 2'b00, 2'd0, 8'd3));
    preempt = 1'b1;
    run_row(mk("pre_yellow",    4'b0000,  1, 4'b0000, 4'b0001, 2'b00, 2'd0, 8'd0));
    run_row(mk("pre_allred",    4'b0000,  4, 4'b0000, 4'b0000, 2'b00, 2'd0, 8'd0));
    run_row(mk("pre_hold",      4'b0000,  1, 4'b0000, 4'b0000, 2'b00, 2'd0, 8'd0));
    run_row(mk("pre_hold_t5",   4'b0000,  5, 4'b0000, 4'b0000, 2'b00, 2'd0, 8'd5));
    preempt = 1'b0;
    run_row(mk("pre_release",   4'b0000,  1, 4'b0000, 4'b0000, 2'b00, 2'd0, 8'd0));
    run_row(mk("pre_green",     4'b0000,  2, 4'b0001, 4'b0000, 2'b00, 2'd0, 8'd0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
